fpu_issue: RTL and testbench
============================

Name: fpu_issue

Overview:
- Issue/writeback controller directly upstream of the floating-point unit (fpu).
- Accepts one decoded float instruction (ADDF, FTOI, ITOF, MULF, RECF, SUBF) from the pipeline and drives the fpu operand/enable interface.
- Waits on the fpu's sticky done flag, then returns the result as a single-cycle register-file write.
- Stalls the pipeline via req_ready while busy, and bounds every operation with a watchdog timeout.

Parameters:
- TIMEOUT, 15: maximum cycles spent in ARM+WAIT before the operation is aborted.
- CW, 4: width of the watchdog counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline presents an instruction.
- req_ready  out  1  high only in IDLE; transfer occurs when req_valid & req_ready.
- req_op  in  5  opcode (5'h11..5'h16 legal).
- req_rd  in  4  destination register index.
- req_a  in  16  operand routed to fpu op1.
- req_b  in  16  operand routed to fpu op2.
- fpu_en  out  1  fpu enable.
- fpu_instr  out  5  latched opcode.
- fpu_op1  out  16  latched req_a.
- fpu_op2  out  16  latched req_b.
- fpu_result  in  16  fpu result.
- fpu_done  in  1  fpu completion flag; sticky, and cleared by the fpu on its first enabled edge.
- wb_en  out  1  register write strobe.
- wb_rd  out  4  write index.
- wb_data  out  16  write data.
- busy  out  1  high in ARM, WAIT and WB.
- err  out  1  one-cycle pulse on timeout or illegal opcode.

Behaviour:
- Reset (asynchronous): state=IDLE; fpu_en, wb_en, err, counter = 0; fpu_instr, fpu_op1, fpu_op2, wb_rd, wb_data = 0.
- All outputs are registered except req_ready and busy, which decode directly from state.
- States: IDLE, ARM, WAIT, WB.
- IDLE:
  - req_ready=1.
  - On transfer with a legal opcode: latch op/rd/a/b, set fpu_en<=1, counter<=0, go to ARM.
  - On transfer with an illegal opcode: the instruction is consumed, err pulses next cycle, there is no writeback, and the state stays IDLE.
- ARM (exactly 1 cycle): fpu_en=1; fpu_done is ignored because it is still stale from the previous operation.
- WAIT:
  - fpu_en=1; counter increments each cycle in ARM and WAIT.
  - If fpu_done=1: wb_data<=fpu_result, fpu_en<=0, go to WB.
  - Else if counter==TIMEOUT-1: wb_data<=16'h0000, err<=1, fpu_en<=0, go to WB.
  - If done and timeout occur in the same cycle, done wins (no err).
- WB (1 cycle): wb_en=1, wb_rd=latched rd; next state IDLE with wb_en<=0.
- Latency: transfer edge → ARM → at least 1 WAIT cycle → WB. Minimum 3 cycles from acceptance to wb_en.
- Throughput: a new request is accepted in the cycle after WB. No request is accepted in ARM, WAIT or WB (req_ready=0), so req_* values changing while busy have no effect.
- Operands are held stable at fpu_op1, fpu_op2 and fpu_instr from ARM through WB.
- Reset asserted mid-operation: immediate return to IDLE with fpu_en=0; no wb_en is emitted for the aborted instruction.
- The counter saturates and never wraps; it is cleared on every acceptance.

Test Plan:
- ITOF: req_op=5'h13, req_b=16'd5, rd=3, with an fpu model answering done after 2 cycles with 16'h40A0 → wb_en pulse, wb_rd=3, wb_data=16'h40A0, err=0, 4 cycles from acceptance to wb_en.
- Stale done: fpu_done held at 1 from the prior op, then MULF issued with the model clearing done on the first enabled edge and returning 16'h4100 two cycles later → wb_data=16'h4100, not the stale result.
- Timeout: SUBF (5'h16) with a model that never raises done → err pulse and wb_en with wb_data=16'h0000 exactly TIMEOUT cycles after ARM entry; req_ready returns one cycle later.
- Illegal opcode: req_op=5'h08 → err pulse, no wb_en, fpu_en never asserted, req_ready stays 1.
- Back-to-back: req_valid held high with two RECF ops → second accepted the cycle after the first WB; two distinct wb_en pulses in order, and req_ready=0 throughout busy.
- Reset mid-WAIT: reset asserted asynchronously during WAIT → fpu_en and busy drop immediately, no wb_en, and the next request is served normally.

Source files
------------

// File: rtl/fpu_issue.sv
// Issue/writeback controller sitting in front of the floating-point unit.
// Drives the fpu operand interface, waits on its sticky done flag and returns one register write.
module fpu_issue #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [3:0]  req_rd,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        fpu_en,
  output logic [4:0]  fpu_instr,
  output logic [15:0] fpu_op1,
  output logic [15:0] fpu_op2,
  input  logic [15:0] fpu_result,
  input  logic        fpu_done,
  output logic        wb_en,
  output logic [3:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          op_legal;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign op_legal  = (req_op >= 5'h11) && (req_op <= 5'h16);
  // Watchdog saturates instead of wrapping.
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      fpu_en    <= 1'b0;
      fpu_instr <= '0;
      fpu_op1   <= '0;
      fpu_op2   <= '0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      err   <= 1'b0;
      wb_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (op_legal) begin
              state     <= S_ARM;
              fpu_en    <= 1'b1;
              cnt       <= '0;
              fpu_instr <= req_op;
              fpu_op1   <= req_a;
              fpu_op2   <= req_b;
              wb_rd     <= req_rd;
            end else begin
              err <= 1'b1;
            end
          end
        end
        // done is still stale from the previous operation here, so it is not looked at.
        S_ARM: begin
          state <= S_WAIT;
          cnt   <= cnt_inc;
        end
        S_WAIT: begin
          cnt <= cnt_inc;
          if (fpu_done) begin
            wb_data <= fpu_result;
            fpu_en  <= 1'b0;
            wb_en   <= 1'b1;
            state   <= S_WB;
          end else if (cnt == TO_LAST) begin
            wb_data <= '0;
            err     <= 1'b1;
            fpu_en  <= 1'b0;
            wb_en   <= 1'b1;
            state   <= S_WB;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// Self-checking bench for fpu_issue: fpu responder, cycle-level reference model and directed scenarios.
module tb_fpu_issue;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic [3:0]  req_rd = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        fpu_en;
  logic [4:0]  fpu_instr;
  logic [15:0] fpu_op1;
  logic [15:0] fpu_op2;
  logic [15:0] fpu_result = '0;
  logic        fpu_done = 1'b0;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        busy;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpu_issue #(.TIMEOUT(TIMEOUT), .CW(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rd(req_rd),
    .req_a(req_a), .req_b(req_b),
    .fpu_en(fpu_en), .fpu_instr(fpu_instr), .fpu_op1(fpu_op1), .fpu_op2(fpu_op2),
    .fpu_result(fpu_result), .fpu_done(fpu_done),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy), .err(err)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // fpu responder: sticky done, cleared on first enabled edge, raised fpu_lat edges later (never if < 0)
  int          fpu_lat = -1;
  logic [15:0] fpu_val = '0;
  bit          fpu_started = 1'b0;
  int          fpu_d = 0;

  always @(posedge clk) begin
    if (!fpu_en) begin
      fpu_started <= 1'b0;
    end else if (!fpu_started) begin
      fpu_started <= 1'b1;
      fpu_d       <= 0;
      fpu_done    <= 1'b0;
    end else begin
      fpu_d <= fpu_d + 1;
      if (fpu_lat >= 0 && fpu_d + 1 == fpu_lat) begin
        fpu_done   <= 1'b1;
        fpu_result <= fpu_val;
      end
    end
  end

  // Reference model: tracks edges since acceptance and decides the outcome of each instruction.
  function automatic bit legal(input logic [4:0] op);
    return (op >= 5'h11) && (op <= 5'h16);
  endfunction

  bit          m_active = 1'b0;
  bit          m_wb = 1'b0;
  int          m_age = 0;
  logic        e_fpu_en = 1'b0;
  logic        e_wb_en = 1'b0;
  logic        e_err = 1'b0;
  logic [4:0]  e_op = '0;
  logic [3:0]  e_rd = '0;
  logic [15:0] e_a = '0;
  logic [15:0] e_b = '0;
  logic [15:0] e_data = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_wb     <= 1'b0;
      m_age    <= 0;
      e_fpu_en <= 1'b0;
      e_wb_en  <= 1'b0;
      e_err    <= 1'b0;
    end else begin
      e_err   <= 1'b0;
      e_wb_en <= 1'b0;
      if (m_wb) begin
        m_wb <= 1'b0;
      end else if (!m_active) begin
        if (req_valid) begin
          if (legal(req_op)) begin
            m_active <= 1'b1;
            m_age    <= 0;
            e_op     <= req_op;
            e_rd     <= req_rd;
            e_a      <= req_a;
            e_b      <= req_b;
            e_fpu_en <= 1'b1;
          end else begin
            e_err <= 1'b1;
          end
        end
      end else begin
        m_age <= m_age + 1;
        if (m_age + 1 >= 2 && fpu_done) begin
          m_active <= 1'b0;
          m_wb     <= 1'b1;
          e_wb_en  <= 1'b1;
          e_data   <= fpu_result;
          e_fpu_en <= 1'b0;
        end else if (m_age + 1 == TIMEOUT) begin
          m_active <= 1'b0;
          m_wb     <= 1'b1;
          e_wb_en  <= 1'b1;
          e_err    <= 1'b1;
          e_data   <= '0;
          e_fpu_en <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("req_ready", req_ready, !(m_active || m_wb));
    check("busy", busy, m_active || m_wb);
    check("fpu_en", fpu_en, e_fpu_en);
    check("wb_en", wb_en, e_wb_en);
    check("err", err, e_err);
    if (e_wb_en) begin
      check("wb_rd", wb_rd, e_rd);
      check("wb_data", wb_data, e_data);
    end
    if (m_active || m_wb) begin
      check("fpu_instr", fpu_instr, e_op);
      check("fpu_op1", fpu_op1, e_a);
      check("fpu_op2", fpu_op2, e_b);
    end
  end

  // Present a request at a negedge and return at the negedge after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [3:0] rd, input logic [15:0] a,
                       input logic [15:0] b, input bit hold);
    bit r;
    bit ok;
    req_valid = 1'b1;
    req_op = op;
    req_rd = rd;
    req_a = a;
    req_b = b;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      r = req_ready;
      @(negedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_bound", 16'(ok), 16'(1));
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_wb(output int n);
    n = 0;
    while (wb_en !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;

  initial begin
    @(negedge clk);
    check("rst_ready", req_ready, 16'h1);
    check("rst_busy", busy, 16'h0);
    check("rst_fpu_op1", fpu_op1, 16'h0);
    check("rst_wb_data", wb_data, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ITOF, done two cycles after the first enabled edge
    fpu_lat = 2;
    fpu_val = 16'h40A0;
    issue(5'h13, 4'd3, 16'h0000, 16'd5, 1'b0);
    wait_wb(n);
    check("itof_latency", 16'(n), 16'd4);
    check("itof_wb_rd", wb_rd, 16'h3);
    check("itof_wb_data", wb_data, 16'h40A0);
    check("itof_err", err, 16'h0);
    @(negedge clk);

    // MULF with done still high from ITOF
    fpu_val = 16'h4100;
    issue(5'h14, 4'd7, 16'h4000, 16'h4080, 1'b0);
    wait_wb(n);
    check("stale_latency", 16'(n), 16'd4);
    check("stale_wb_data", wb_data, 16'h4100);
    @(negedge clk);

    // SUBF with an fpu that never answers
    fpu_lat = -1;
    issue(5'h16, 4'd9, 16'h1234, 16'h5678, 1'b0);
    wait_wb(n);
    check("timeout_latency", 16'(n), 16'(TIMEOUT));
    check("timeout_err", err, 16'h1);
    check("timeout_wb_data", wb_data, 16'h0000);
    check("timeout_wb_rd", wb_rd, 16'h9);
    @(negedge clk);
    check("timeout_ready_back", req_ready, 16'h1);
    check("timeout_err_clear", err, 16'h0);

    // Illegal opcode
    issue(5'h08, 4'd2, 16'hAAAA, 16'hBBBB, 1'b0);
    check("illegal_err", err, 16'h1);
    check("illegal_ready", req_ready, 16'h1);
    check("illegal_fpu_en", fpu_en, 16'h0);
    repeat (3) begin
      @(negedge clk);
      check("illegal_no_wb", wb_en, 16'h0);
      check("illegal_no_en", fpu_en, 16'h0);
    end

    // Back-to-back RECF with req_valid held high
    fpu_lat = 2;
    fpu_val = 16'h3C00;
    issue(5'h15, 4'd1, 16'h0101, 16'h0202, 1'b1);
    req_rd = 4'd2;
    req_a = 16'h0303;
    req_b = 16'h0404;
    wait_wb(n);
    check("b2b_first_latency", 16'(n), 16'd4);
    check("b2b_first_rd", wb_rd, 16'h1);
    check("b2b_first_data", wb_data, 16'h3C00);
    fpu_val = 16'h3800;
    @(negedge clk);
    check("b2b_ready_after_wb", req_ready, 16'h1);
    @(negedge clk);
    check("b2b_second_accepted", busy, 16'h1);
    check("b2b_second_op1", fpu_op1, 16'h0303);
    req_valid = 1'b0;
    wait_wb(n);
    check("b2b_second_latency", 16'(n), 16'd4);
    check("b2b_second_rd", wb_rd, 16'h2);
    check("b2b_second_data", wb_data, 16'h3800);
    @(negedge clk);

    // Asynchronous reset during WAIT
    fpu_lat = -1;
    issue(5'h16, 4'd5, 16'h0F0F, 16'hF0F0, 1'b0);
    repeat (2) @(negedge clk);
    check("pre_reset_busy", busy, 16'h1);
    #2 reset = 1'b1;
    #1;
    check("async_fpu_en", fpu_en, 16'h0);
    check("async_busy", busy, 16'h0);
    check("async_wb_en", wb_en, 16'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    fpu_lat = 2;
    fpu_val = 16'h5555;
    issue(5'h11, 4'd4, 16'h1111, 16'h2222, 1'b0);
    wait_wb(n);
    check("post_reset_latency", 16'(n), 16'd4);
    check("post_reset_rd", wb_rd, 16'h4);
    check("post_reset_data", wb_data, 16'h5555);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
